// File: rtl/uart_byte_to_bcd_pkg.sv
// Shared types and constants for the UART-to-display path: converter FSM
// states, the BCD nibble type and the code the digit decoders render as '-'.
package uart_disp_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef logic [3:0] bcd_nibble_t;

  localparam bcd_nibble_t INVALID_DIGIT = 4'hA;

  // True when ndig decimal digits can hold every unsigned data_w-bit value,
  // i.e. 10^ndig > 2^data_w. Evaluated at elaboration only.
  function automatic bit ndig_fits(input int ndig, input int data_w);
    longint p10;
    p10 = 1;
    for (int i = 0; i < ndig; i++) begin
      p10 = p10 * 10;
    end
    return p10 > (longint'(1) << data_w);
  endfunction

endpackage

// File: rtl/uart_byte_to_bcd_if.sv
// Byte-in / digits-out bundle between the UART receiver (master) and the
// BCD converter (slave).
//
// Handshake: a word transfers on a rising clock edge where in_valid and
// in_ready are both high. in_valid is not required to be held; a word
// presented while in_ready is low is simply not taken. digits changes only
// on the edge that raises done, and holds otherwise.
interface uart_byte_to_bcd_if #(
  parameter int DATA_W = 8,
  parameter int NDIG   = 3
);

  logic                in_valid;
  logic [DATA_W-1:0]   in_data;
  logic                in_err;
  logic                in_ready;
  logic [4*NDIG-1:0]   digits;
  logic                digits_valid;
  logic                done;
  logic                busy;

  modport master (
    output in_valid, in_data, in_err,
    input  in_ready, digits, digits_valid, done, busy
  );

  modport slave (
    input  in_valid, in_data, in_err,
    output in_ready, digits, digits_valid, done, busy
  );

endinterface

// File: rtl/uart_byte_to_bcd_add3.sv
// One double-dabble correction nibble: values 5..9 get +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3_nibble
  import uart_disp_pkg::*;
(
  input  bcd_nibble_t value,
  output bcd_nibble_t adjusted
);

  // Wraps at 4 bits; inputs above 9 never occur during a legal conversion.
  assign adjusted = (value >= 4'd5) ? bcd_nibble_t'(value + 4'd3) : value;

endmodule

// File: rtl/uart_byte_to_bcd.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// feeding the per-digit seven-segment decoders. Error-flagged words show
// dashes on every digit.
module uart_byte_to_bcd
  import uart_disp_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NDIG   = 3
) (
  input  logic                clk,
  input  logic                rst,
  uart_byte_to_bcd_if.slave   bus,
  output state_t              state_dbg
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BCD_W = 4 * NDIG;

  // Refuse to build a converter whose digit count cannot hold the input range.
  if (!ndig_fits(NDIG, DATA_W)) begin : g_ndig_check
    $error("uart_byte_to_bcd: NDIG=%0d too small for DATA_W=%0d", NDIG, DATA_W);
  end

  state_t              state;
  state_t              state_next;
  logic [DATA_W-1:0]   bin;
  logic [BCD_W-1:0]    scratch;
  logic [BCD_W-1:0]    scratch_adj;
  logic [CNT_W-1:0]    cnt;
  logic [BCD_W-1:0]    digits;
  logic                digits_valid;
  logic                done;
  logic                err_pend;
  logic                accept;
  logic                last_shift;
  logic [BCD_W+DATA_W-1:0] shifted;

  assign accept     = bus.in_valid && (state == IDLE);
  assign last_shift = (state == SHIFT) && (cnt == CNT_W'(1));

  for (genvar k = 0; k < NDIG; k++) begin : g_add3
    bcd_add3_nibble u_add3 (
      .value    (scratch[4*k +: 4]),
      .adjusted (scratch_adj[4*k +: 4])
    );
  end

  // Corrected scratch and binary register move left as one, so the binary
  // MSB lands in scratch bit 0.
  assign shifted = {scratch_adj, bin} << 1;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: only error-free words start a conversion; the last shift returns to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && !bus.in_err) state_next = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1))      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: load on accept, shift while converting, publish result or dashes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin          <= '0;
      scratch      <= '0;
      cnt          <= '0;
      digits       <= {NDIG{INVALID_DIGIT}};
      digits_valid <= 1'b0;
      done         <= 1'b0;
      err_pend     <= 1'b0;
    end else begin
      done     <= 1'b0;
      err_pend <= accept && bus.in_err;

      // An error word accepted last edge shows dashes one edge later.
      if (err_pend) begin
        digits       <= {NDIG{INVALID_DIGIT}};
        done         <= 1'b1;
        digits_valid <= 1'b1;
      end

      if (accept && !bus.in_err) begin
        bin     <= bus.in_data;
        scratch <= '0;
        cnt     <= CNT_W'(DATA_W);
      end else if (state == SHIFT) begin
        scratch <= shifted[BCD_W+DATA_W-1 -: BCD_W];
        bin     <= shifted[DATA_W-1:0];
        cnt     <= cnt - CNT_W'(1);
        if (last_shift) begin
          digits       <= shifted[BCD_W+DATA_W-1 -: BCD_W];
          done         <= 1'b1;
          digits_valid <= 1'b1;
        end
      end
    end
  end

  assign bus.in_ready     = (state == IDLE);
  assign bus.busy         = (state == SHIFT);
  assign bus.digits       = digits;
  assign bus.digits_valid = digits_valid;
  assign bus.done         = done;
  assign state_dbg        = state;

endmodule

// File: tb/tb_uart_byte_to_bcd.sv
// Bench for uart_byte_to_bcd: directed scenarios plus a full sweep of byte
// values, with a cycle-level model checking every output on every cycle.
module tb_uart_byte_to_bcd;
  import uart_disp_pkg::*;

  localparam int DATA_W = 8;
  localparam int NDIG   = 3;
  localparam int W      = 4 * NDIG;
  localparam logic [W-1:0] ALL_DASH = 12'hAAA;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst = 1'b1;
  state_t state_dbg;

  always #5 clk = ~clk;

  uart_byte_to_bcd_if #(.DATA_W(DATA_W), .NDIG(NDIG)) bus ();

  uart_byte_to_bcd #(.DATA_W(DATA_W), .NDIG(NDIG)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Decimal digits of v, ones in nibble 0.
  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < NDIG; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // ---------------- scoreboard / model ----------------
  // Model time is the count of rising edges seen; each accepted word
  // schedules its result for a known edge number.
  logic [W-1:0] exp_q[$];
  int           exp_t[$];
  int           cyc       = 0;
  int           ready_at  = 0;
  logic [W-1:0] exp_digits = 12'hAAA;
  logic         exp_valid  = 1'b0;
  logic         exp_done;
  logic         exp_ready;

  // Negative edge: outputs of the edge just passed are settled and the
  // inputs for the coming edge are already stable.
  always @(negedge clk) begin
    cyc++;
    exp_done = 1'b0;
    if (rst) begin
      exp_q.delete();
      exp_t.delete();
      ready_at   = 0;
      exp_digits = ALL_DASH;
      exp_valid  = 1'b0;
    end else if (exp_t.size() > 0 && exp_t[0] == cyc) begin
      exp_done   = 1'b1;
      exp_digits = exp_q.pop_front();
      void'(exp_t.pop_front());
      exp_valid  = 1'b1;
    end
    exp_ready = rst || (cyc + 1 >= ready_at);

    chk("done",         bus.done,         exp_done);
    chk("digits",       bus.digits,       exp_digits);
    chk("digits_valid", bus.digits_valid, exp_valid);
    chk("in_ready",     bus.in_ready,     exp_ready);
    chk("busy",         bus.busy,         !exp_ready);
    chk("state",        state_dbg,        exp_ready ? IDLE : SHIFT);

    // Acceptance at the next edge.
    if (!rst && bus.in_valid && (cyc + 1 >= ready_at)) begin
      if (bus.in_err) begin
        exp_t.push_back(cyc + 2);
        exp_q.push_back(ALL_DASH);
      end else begin
        exp_t.push_back(cyc + 1 + DATA_W);
        exp_q.push_back(to_bcd(int'(bus.in_data)));
        ready_at = cyc + 1 + DATA_W + 1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one word for one edge; called 2 time units after a rising edge.
  task automatic send(input logic [7:0] d, input logic e);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_err   = e;
    @(posedge clk);
    #2;
    bus.in_valid = 1'b0;
    bus.in_err   = 1'b0;
  endtask

  // Wait (bounded) for done; lat = edges waited, bc = cycles busy was seen high.
  task automatic wait_done(output int lat, output int bc);
    bit got;
    got = 1'b0;
    lat = 0;
    bc  = int'(bus.busy);
    while (!got && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.done) got = 1'b1;
      else bc += int'(bus.busy);
    end
    #1;
    chk("done_seen", got, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int lat, bc, pulses;
  int order[256];

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_err   = 1'b0;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_digits",   bus.digits, ALL_DASH);
    chk("rst_valid",    bus.digits_valid, 1'b0);
    chk("rst_ready",    bus.in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #2;

    // Zero.
    send(8'h00, 1'b0);
    wait_done(lat, bc);
    chk("zero_latency", lat, 8);
    chk("zero_digits",  bus.digits, 12'h000);
    chk("zero_valid",   bus.digits_valid, 1'b1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", bus.done, 1'b0);
    #1;

    // Largest byte, busy exactly DATA_W cycles.
    send(8'hFF, 1'b0);
    wait_done(lat, bc);
    chk("ff_latency", lat, 8);
    chk("ff_busy_cycles", bc, 8);
    chk("ff_digits", bus.digits, 12'h255);

    // 0x7B accepted, then a new word held valid while converting.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h7B;
    @(posedge clk);
    #2;
    bus.in_data = 8'h01;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("busy_ready_low", bus.in_ready, 1'b0);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_done(lat, bc);
    chk("7b_latency", lat, 3);
    chk("7b_digits", bus.digits, 12'h123);
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      pulses += int'(bus.done);
      #1;
    end
    chk("ignored_word_no_done", pulses, 0);

    // Error word, then two error words back to back.
    send(8'h41, 1'b1);
    wait_done(lat, bc);
    chk("err_latency", lat, 1);
    chk("err_digits", bus.digits, ALL_DASH);
    send(8'h05, 1'b0);
    wait_done(lat, bc);
    chk("five_digits", bus.digits, 12'h005);
    bus.in_valid = 1'b1;
    bus.in_err   = 1'b1;
    bus.in_data  = 8'h41;
    @(posedge clk);
    #1;
    chk("b2b_ready", bus.in_ready, 1'b1);
    @(posedge clk);
    #1;
    chk("b2b_done1", bus.done, 1'b1);
    chk("b2b_digits", bus.digits, ALL_DASH);
    bus.in_valid = 1'b0;
    bus.in_err   = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b_done2", bus.done, 1'b1);
    @(posedge clk);
    #1;
    chk("b2b_done_end", bus.done, 1'b0);
    #1;

    // Reset in the middle of converting 99.
    send(8'h63, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_digits", bus.digits, ALL_DASH);
    chk("midrst_valid",  bus.digits_valid, 1'b0);
    chk("midrst_ready",  bus.in_ready, 1'b1);
    chk("midrst_busy",   bus.busy, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #2;
    send(8'h09, 1'b0);
    wait_done(lat, bc);
    chk("after_rst_latency", lat, 8);
    chk("after_rst_digits",  bus.digits, 12'h009);

    // All byte values in shuffled order, back to back at full rate.
    for (int i = 0; i < 256; i++) order[i] = i;
    for (int i = 0; i < 255; i++) begin
      int j;
      int t;
      j = int'($urandom_range(255, i));
      t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int i = 0; i < 256; i++) begin
      send(8'(order[i]), 1'b0);
      wait_done(lat, bc);
      chk("sweep_digits", bus.digits, to_bcd(order[i]));
    end

    repeat (3) @(posedge clk);
    #2;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
